level_two_arbiter: RTL

Arbiter sharing the single 256-bit level-two cache port between the level-one instruction cache and the level-one data cache. It sits between the split level-one caches and `level_two_cache`. It grants one line transaction at a time, holds the grant until the level-two cache responds, and routes the response back to the granted requester only.

---
 rtl/level_two_arbiter_pkg.sv | 9 +
 rtl/level_two_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/level_two_arbiter_pkg.sv
// Shared types for the level-two port arbiter: FSM states, grant sides and
// the default line/address widths.
package level_two_arbiter_types;
   localparam int L2_ADDR_WIDTH = 32;
   localparam int L2_LINE_WIDTH = 256;

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
   typedef enum logic {GRANT_I, GRANT_D} arb_grant_t;
endpackage

// File: rtl/level_two_arbiter.sv
// Shares the single level-two cache port between the split L1 caches, one
// line transaction at a time. Build macro LEVEL_TWO_ARBITER_ROUND_ROBIN_EN
// selects alternating tie-breaks; otherwise the data side always wins ties.
module level_two_arbiter
   import level_two_arbiter_types::*;
#(
   parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
   parameter int LINE_WIDTH = L2_LINE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] icache_addr,
   input  logic                  icache_read,
   output logic [LINE_WIDTH-1:0] icache_rdata,
   output logic                  icache_resp,
   input  logic [ADDR_WIDTH-1:0] dcache_addr,
   input  logic                  dcache_read,
   input  logic                  dcache_write,
   input  logic [LINE_WIDTH-1:0] dcache_wdata,
   output logic [LINE_WIDTH-1:0] dcache_rdata,
   output logic                  dcache_resp,
   output logic [ADDR_WIDTH-1:0] addr_to_level_two_cache,
   input  logic [LINE_WIDTH-1:0] rdata_from_level_two_cache,
   output logic [LINE_WIDTH-1:0] wdata_to_level_two_cache,
   output logic                  read_to_level_two_cache,
   output logic                  write_to_level_two_cache,
   input  logic                  resp_from_level_two_cache
);
   arb_state_t state;
   arb_grant_t pick;
   logic       i_req, d_req;

   assign i_req = icache_read;
   assign d_req = dcache_read | dcache_write;

`ifdef LEVEL_TWO_ARBITER_ROUND_ROBIN_EN
   arb_grant_t last_grant;
`endif

   // Grant decision, only consulted when leaving IDLE with a request pending.
   always_comb begin
      pick = GRANT_D;
      if (i_req && !d_req)
         pick = GRANT_I;
      else if (i_req && d_req) begin
`ifdef LEVEL_TWO_ARBITER_ROUND_ROBIN_EN
         pick = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
`else
         pick = GRANT_D;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
`ifdef LEVEL_TWO_ARBITER_ROUND_ROBIN_EN
         last_grant <= GRANT_I;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  state <= (pick == GRANT_I) ? SERVE_I : SERVE_D;
`ifdef LEVEL_TWO_ARBITER_ROUND_ROBIN_EN
                  last_grant <= pick;
`endif
               end
            end
            // Returning to IDLE on resp leaves one bubble cycle, so a requester
            // still holding read in its resp cycle is not issued twice.
            SERVE_I, SERVE_D: if (resp_from_level_two_cache) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      addr_to_level_two_cache  = '0;
      wdata_to_level_two_cache = '0;
      read_to_level_two_cache  = 1'b0;
      write_to_level_two_cache = 1'b0;
      case (state)
         SERVE_I: begin
            addr_to_level_two_cache = icache_addr;
            read_to_level_two_cache = 1'b1;
         end
         SERVE_D: begin
            addr_to_level_two_cache  = dcache_addr;
            wdata_to_level_two_cache = dcache_wdata;
            read_to_level_two_cache  = dcache_read;
            write_to_level_two_cache = dcache_write;
         end
         default: ;
      endcase
   end

   assign icache_resp  = resp_from_level_two_cache & (state == SERVE_I);
   assign dcache_resp  = resp_from_level_two_cache & (state == SERVE_D);
   assign icache_rdata = rdata_from_level_two_cache;
   assign dcache_rdata = rdata_from_level_two_cache;
endmodule
